// File: rtl/qam_mapper_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qam_mapper_controller_pkg                                            |
// | Shared state encodings and 16-QAM level constants.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package qam_mapper_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOAD     = 2'b01,
        ST_TRANSMIT = 2'b10,
        ST_DONE     = 2'b11
    } state_t;

    // Two's-complement 3-bit amplitude levels
    localparam logic [2:0] c_lvl_m3   = 3'b101;
    localparam logic [2:0] c_lvl_m1   = 3'b111;
    localparam logic [2:0] c_lvl_p1   = 3'b001;
    localparam logic [2:0] c_lvl_p3   = 3'b011;
    localparam logic [2:0] c_lvl_zero = 3'b000;

    localparam int c_bits_per_sym = 4;

endpackage
`default_nettype wire

// File: rtl/qam_symbol_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qam_symbol_fifo                                                      |
// | Synchronous FIFO with occupancy counter and single-cycle flush.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module qam_symbol_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == (c_aw+1)'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/qam_mapper_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qam_mapper_controller                                                |
// | Buffers 16-QAM symbol words and emits Gray-mapped I/Q levels.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module qam_mapper_controller
    import qam_mapper_controller_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      dclk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      wr_en,
    input  logic [c_bits_per_sym-1:0] wr_data,
    input  logic                      start,
    input  logic                      sym_stb,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      busy,
    output logic                      complete,
    output logic                      sym_valid,
    output logic [2:0]                i_out,
    output logic [2:0]                q_out,
    output logic [1:0]                state
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_overflow;
    logic                      r_sym_valid;
    logic [2:0]                r_i;
    logic [2:0]                r_q;
    logic [c_bits_per_sym-1:0] w_rd_data;
    logic                      w_in_load;
    logic                      w_in_tx;
    logic                      w_push;
    logic                      w_drop;
    logic                      w_pop;
    logic                      w_underrun;
    logic                      w_flush;

    function automatic logic [2:0] gray_level(input logic [1:0] bits);
        logic [2:0] lvl;
        case (bits)
            2'b00:   lvl = c_lvl_m3;
            2'b01:   lvl = c_lvl_m1;
            2'b11:   lvl = c_lvl_p1;
            default: lvl = c_lvl_p3;
        endcase
        return lvl;
    endfunction

    // Every action is gated by enable so that dropping it wins over all else
    assign w_in_load  = enable && (r_state == ST_LOAD);
    assign w_in_tx    = enable && (r_state == ST_TRANSMIT);
    assign w_push     = w_in_load && wr_en && !full;
    assign w_drop     = w_in_load && wr_en && full;
    assign w_pop      = w_in_tx && sym_stb && !empty;
    assign w_underrun = w_in_tx && sym_stb && empty;
    assign w_flush    = (w_state_next == ST_IDLE);

    qam_symbol_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_bits_per_sym)
    ) u_fifo (
        .clk     (dclk),
        .rst     (reset),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (w_flush),
        .wr_data (wr_data),
        .rd_data (w_rd_data),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_next = ST_LOAD;
                ST_LOAD:     if (start && !empty) w_state_next = ST_TRANSMIT;
                ST_TRANSMIT: if (sym_stb && empty) w_state_next = ST_DONE;
                ST_DONE:     if (!start) w_state_next = ST_LOAD;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_flush) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            r_sym_valid <= 1'b0;
            r_i         <= c_lvl_zero;
            r_q         <= c_lvl_zero;
        end else if (w_pop) begin
            r_sym_valid <= 1'b1;
            r_i         <= gray_level(w_rd_data[3:2]);
            r_q         <= gray_level(w_rd_data[1:0]);
        end else if (w_underrun) begin
            r_sym_valid <= 1'b0;
            r_i         <= c_lvl_zero;
            r_q         <= c_lvl_zero;
        end else begin
            r_sym_valid <= 1'b0;
        end
    end

    assign overflow  = r_overflow;
    assign sym_valid = r_sym_valid;
    assign i_out     = r_i;
    assign q_out     = r_q;
    assign state     = r_state;
    assign busy      = (r_state == ST_TRANSMIT);
    assign complete  = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_qam_mapper_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_qam_mapper_controller                                             |
// | Directed stimulus with a queue-based scoreboard on sym_valid.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_qam_mapper_controller;

    logic       dclk;
    logic       reset;
    logic       enable;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       start;
    logic       sym_stb;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       busy;
    logic       complete;
    logic       sym_valid;
    logic [2:0] i_out;
    logic [2:0] q_out;
    logic [1:0] state;

    typedef struct {
        int i;
        int q;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   n_valid = 0;
    exp_t m_e;
    int   m_ai;
    int   m_aq;

    qam_mapper_controller #(.DEPTH(16)) dut (
        .dclk      (dclk),
        .reset     (reset),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .start     (start),
        .sym_stb   (sym_stb),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .busy      (busy),
        .complete  (complete),
        .sym_valid (sym_valid),
        .i_out     (i_out),
        .q_out     (q_out),
        .state     (state)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    // Hand table of the Gray mapping: 00->-3, 01->-1, 11->+1, 10->+3
    function automatic int lvl(input logic [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    task automatic push_exp(input logic [3:0] w);
        exp_t e;
        e.i = lvl(w[3:2]);
        e.q = lvl(w[1:0]);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic stb_pulse();
        sym_stb = 1'b1;
        step();
        sym_stb = 1'b0;
    endtask

    always @(negedge dclk) begin
        if (sym_valid === 1'b1) begin
            n_valid++;
            checks++;
            m_ai = $signed(i_out);
            m_aq = $signed(q_out);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sym_valid: got i=%0d q=%0d expected no symbol", m_ai, m_aq);
            end else begin
                m_e = sb.pop_front();
                if (m_ai != m_e.i || m_aq != m_e.q) begin
                    errors++;
                    $display("FAIL symbol_iq: got i=%0d q=%0d expected i=%0d q=%0d",
                             m_ai, m_aq, m_e.i, m_e.q);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_data = 4'h0;
        start = 1'b0; sym_stb = 1'b0;
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_complete", complete, 0);
        chk("rst_sym_valid", sym_valid, 0);
        chk("rst_iq", {i_out, q_out}, 0);

        reset = 1'b0;
        step();
        chk("idle_no_enable", state, 0);
        enable = 1'b1;
        step();
        chk("load_state", state, 1);
        chk("load_empty", empty, 1);
        chk("load_iq", {i_out, q_out}, 0);
        chk("load_flags", {busy, complete, sym_valid, overflow}, 0);

        // Four-symbol transmission with a write during Transmit
        write_word(4'h0); write_word(4'h5); write_word(4'hF); write_word(4'hA);
        start = 1'b1; step(); start = 1'b0;
        chk("tx_state", state, 2);
        chk("tx_busy", busy, 1);
        push_exp(4'h0); stb_pulse(); step();
        push_exp(4'h5); stb_pulse(); step();
        write_word(4'h7);
        push_exp(4'hF); stb_pulse(); step();
        push_exp(4'hA); stb_pulse(); step();
        stb_pulse();
        chk("underrun_iq", {i_out, q_out}, 0);
        chk("underrun_valid", sym_valid, 0);
        chk("done_state", state, 3);
        chk("done_complete", complete, 1);
        chk("tx_overflow", overflow, 0);
        chk("nvalid_4", n_valid, 4);

        wr_en = 1'b1; wr_data = 4'h9; start = 1'b1; step(); wr_en = 1'b0;
        chk("done_hold", state, 3);
        chk("done_wr_empty", empty, 1);
        chk("done_wr_overflow", overflow, 0);
        start = 1'b0; step();
        chk("done_to_load", state, 1);

        // Fill to DEPTH then one extra write
        for (int k = 0; k < 16; k++) write_word(4'(k));
        chk("full_at_16", full, 1);
        chk("no_ovf_at_16", overflow, 0);
        write_word(4'h3);
        chk("ovf_at_17", overflow, 1);
        start = 1'b1; step(); start = 1'b0;
        chk("tx2_state", state, 2);
        for (int k = 0; k < 16; k++) begin
            push_exp(4'(k)); stb_pulse(); step();
        end
        stb_pulse();
        chk("done2_state", state, 3);
        chk("ovf_sticky", overflow, 1);
        chk("nvalid_20", n_valid, 20);

        // Enable drops together with sym_stb
        step();
        chk("load3_state", state, 1);
        write_word(4'h5); write_word(4'hA);
        start = 1'b1; step(); start = 1'b0;
        push_exp(4'h5); stb_pulse(); step();
        sym_stb = 1'b1; enable = 1'b0; step(); sym_stb = 1'b0;
        chk("drop_valid", sym_valid, 0);
        chk("drop_state", state, 0);
        chk("drop_empty", empty, 1);
        chk("drop_ovf_clear", overflow, 0);
        step();
        chk("nvalid_21", n_valid, 21);

        // Reset in the middle of an 8-symbol burst
        enable = 1'b1; step();
        chk("load4_state", state, 1);
        write_word(4'h1); write_word(4'h2); write_word(4'h3); write_word(4'h4);
        write_word(4'h6); write_word(4'h7); write_word(4'h8); write_word(4'h9);
        start = 1'b1; step(); start = 1'b0;
        push_exp(4'h1); stb_pulse(); step();
        push_exp(4'h2); stb_pulse(); step();
        reset = 1'b1; #1;
        chk("midrst_iq", {i_out, q_out}, 0);
        chk("midrst_valid", sym_valid, 0);
        chk("midrst_state", state, 0);
        chk("midrst_empty", empty, 1);
        step();
        reset = 1'b0; step();
        chk("postrst_load", state, 1);
        start = 1'b1;
        repeat (3) step();
        chk("start_empty_hold", state, 1);
        stb_pulse(); step(); stb_pulse(); step();
        start = 1'b0;
        chk("stb_in_load", state, 1);
        chk("postrst_empty", empty, 1);
        chk("nvalid_23", n_valid, 23);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
